// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: drains the UART receiver holding register into a circular FIFO
// and re-presents a ready/data/ack interface to the CPU.
// Latency: a byte captured at edge E is on out_data/out_ready, and in_ack is high, in cycle E+1.
// Backpressure: none toward the UART line; a byte arriving while full is dropped and counted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_ready/in_data    receiver holding register (level, held until acked)
//   in_ack              one-cycle pulse per captured byte (accepted or dropped)
//   out_ready/out_data  FIFO non-empty / head byte (0 when empty)
//   out_ack             each high cycle pops one byte; ignored when empty
//   level, full         occupancy 0..2**ADDR_W, full flag
//   overrun, drop_cnt   sticky drop flag, saturating drop count
//   clr_ovr             synchronous clear of overrun/drop_cnt (a same-edge drop wins)
module uart_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ack,
   output logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ack,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              overrun,
   output logic [7:0]        drop_cnt,
   input  logic              clr_ovr
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACK    = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t              state_q;
   logic                in_ack_q;
   logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]     level_q, level_d;
   logic                overrun_q, overrun_d;
   logic [7:0]          drop_cnt_q, drop_cnt_d;
   logic [DATA_W-1:0]   mem [2**ADDR_W];

   logic full_w, capture, push, drop, pop;

   // full is taken from the registered level, so a capture on a popping edge
   // while full is still a drop.
   assign full_w  = (level_q == DEPTH);
   assign capture = (state_q == IDLE) && in_ready;
   assign push    = capture && !full_w;
   assign drop    = capture && full_w;
   assign pop     = out_ack && (level_q != '0);

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      overrun_d  = overrun_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         overrun_d = 1'b1;
         if (clr_ovr)
            drop_cnt_d = 8'd1;
         else if (drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
      end else if (clr_ovr) begin
         overrun_d  = 1'b0;
         drop_cnt_d = 8'd0;
      end
   end

   // Handshake FSM: SETTLE waits for in_ready to fall so one byte is never captured twice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         in_ack_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               in_ack_q <= 1'b0;
               if (in_ready) begin
                  state_q  <= ACK;
                  in_ack_q <= 1'b1;
               end
            end
            ACK: begin
               state_q  <= SETTLE;
               in_ack_q <= 1'b0;
            end
            SETTLE: begin
               in_ack_q <= 1'b0;
               if (!in_ready)
                  state_q <= IDLE;
            end
            default: begin
               state_q  <= IDLE;
               in_ack_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overrun_q  <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q    <= level_d;
         overrun_q  <= overrun_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is deliberately not reset; empty reads are masked to zero below.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_q] <= in_data;
   end

   assign in_ack    = in_ack_q;
   assign out_ready = (level_q != '0);
   assign out_data  = (level_q != '0) ? mem[rd_ptr_q] : '0;
   assign level     = level_q;
   assign full      = full_w;
   assign overrun   = overrun_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, single byte, fill/order, overflow,
// simultaneous push/pop, random wrap traffic with scoreboard, reset mid-handshake.
// Inputs change 1-2 time units after the rising edge; outputs are sampled there too.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_ack;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_ack;
   logic [4:0] level;
   logic       full;
   logic       overrun;
   logic [7:0] drop_cnt;
   logic       clr_ovr;

   int checks   = 0;
   int failures = 0;

   logic [7:0] sb[$];
   bit         push_done;
   int         pops_seen;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ack    (in_ack),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ack   (out_ack),
      .level     (level),
      .full      (full),
      .overrun   (overrun),
      .drop_cnt  (drop_cnt),
      .clr_ovr   (clr_ovr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one byte, wait (bounded) for its ack, hold in_ready 'hold' more
   // cycles, then release and let the FSM return to IDLE.
   task automatic push_byte(input logic [7:0] b, input int hold, input bit rec);
      bit got;
      got      = 1'b0;
      in_ready = 1'b1;
      in_data  = b;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         if (in_ack) got = 1'b1;
      end
      chk("push_ack", {31'd0, got}, 32'd1);
      if (got && rec) sb.push_back(b);
      repeat (hold) tick();
      in_ready = 1'b0;
      tick();
      tick();
   endtask

   task automatic pop_one(input string tag, input logic [7:0] exp);
      chk(tag, {24'd0, out_data}, {24'd0, exp});
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
   endtask

   task automatic drain();
      out_ack = 1'b1;
      for (int i = 0; i < 40 && level != 5'd0; i++) tick();
      out_ack = 1'b0;
      chk("drain_level", {27'd0, level}, 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_ready = 1'b1;
      in_data  = 8'h5A;
      out_ack  = 1'b0;
      clr_ovr  = 1'b0;

      // 1 reset with in_ready high, then capture after release
      repeat (3) tick();
      chk("rst_in_ack",   {31'd0, in_ack},    32'd0);
      chk("rst_out_rdy",  {31'd0, out_ready}, 32'd0);
      chk("rst_level",    {27'd0, level},     32'd0);
      chk("rst_full",     {31'd0, full},      32'd0);
      chk("rst_overrun",  {31'd0, overrun},   32'd0);
      chk("rst_drop_cnt", {24'd0, drop_cnt},  32'd0);
      chk("rst_out_data", {24'd0, out_data},  32'd0);
      rst_n = 1'b1;
      tick();
      chk("rel_level",    {27'd0, level},     32'd1);
      chk("rel_in_ack",   {31'd0, in_ack},    32'd1);
      chk("rel_data",     {24'd0, out_data},  32'h5A);
      in_ready = 1'b0;
      tick();
      tick();
      pop_one("rel_pop", 8'h5A);
      chk("rel_empty", {27'd0, level}, 32'd0);

      // 2 single byte
      in_ready = 1'b1;
      in_data  = 8'h31;
      tick();
      chk("s_in_ack",  {31'd0, in_ack},    32'd1);
      chk("s_out_rdy", {31'd0, out_ready}, 32'd1);
      chk("s_data",    {24'd0, out_data},  32'h31);
      chk("s_level",   {27'd0, level},     32'd1);
      in_ready = 1'b0;
      tick();
      chk("s_ack_pulse", {31'd0, in_ack}, 32'd0);
      tick();
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      chk("s_pop_rdy",   {31'd0, out_ready}, 32'd0);
      chk("s_pop_data",  {24'd0, out_data},  32'd0);
      chk("s_pop_level", {27'd0, level},     32'd0);

      // 3 fill and order
      for (int i = 0; i < 16; i++) push_byte(8'(8'h41 + i), 0, 1'b0);
      chk("fill_full",  {31'd0, full},  32'd1);
      chk("fill_level", {27'd0, level}, 32'd16);

      // 4 overflow while full
      push_byte(8'hAA, 0, 1'b0);
      chk("ovf_level",   {27'd0, level},    32'd16);
      chk("ovf_overrun", {31'd0, overrun},  32'd1);
      chk("ovf_drop",    {24'd0, drop_cnt}, 32'd1);
      for (int i = 0; i < 16; i++) pop_one("order", 8'(8'h41 + i));
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      chk("under_level", {27'd0, level},     32'd0);
      chk("under_rdy",   {31'd0, out_ready}, 32'd0);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      chk("clr_overrun", {31'd0, overrun},  32'd0);
      chk("clr_drop",    {24'd0, drop_cnt}, 32'd0);
      for (int i = 0; i < 16; i++) push_byte(8'(i), 0, 1'b0);
      for (int i = 0; i < 300; i++) push_byte(8'hEE, 0, 1'b0);
      chk("sat_drop",    {24'd0, drop_cnt}, 32'd255);
      chk("sat_overrun", {31'd0, overrun},  32'd1);
      // clear and drop on the same edge: drop wins
      in_ready = 1'b1;
      in_data  = 8'hCC;
      clr_ovr  = 1'b1;
      tick();
      clr_ovr  = 1'b0;
      chk("clrdrop_cnt", {24'd0, drop_cnt}, 32'd1);
      chk("clrdrop_ovr", {31'd0, overrun},  32'd1);
      in_ready = 1'b0;
      tick();
      tick();
      // pop and capture on the same edge while full: byte dropped, pop happens
      in_ready = 1'b1;
      in_data  = 8'hBB;
      out_ack  = 1'b1;
      tick();
      out_ack  = 1'b0;
      chk("fullpop_level", {27'd0, level},    32'd15);
      chk("fullpop_drop",  {24'd0, drop_cnt}, 32'd2);
      chk("fullpop_head",  {24'd0, out_data}, 32'd1);
      in_ready = 1'b0;
      tick();
      tick();
      drain();
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;

      // 5 simultaneous push and pop at level 3
      push_byte(8'h61, 0, 1'b0);
      push_byte(8'h62, 0, 1'b0);
      push_byte(8'h63, 0, 1'b0);
      chk("sim_pre_level", {27'd0, level}, 32'd3);
      in_ready = 1'b1;
      in_data  = 8'h64;
      out_ack  = 1'b1;
      tick();
      out_ack  = 1'b0;
      chk("sim_level", {27'd0, level},    32'd3);
      chk("sim_head",  {24'd0, out_data}, 32'h62);
      in_ready = 1'b0;
      tick();
      tick();
      pop_one("sim_pop0", 8'h62);
      pop_one("sim_pop1", 8'h63);
      pop_one("sim_pop2", 8'h64);
      chk("sim_empty", {27'd0, level}, 32'd0);

      // 6 random traffic with wrap, scoreboard ordered
      push_done = 1'b0;
      pops_seen = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               push_byte(8'($urandom), $urandom_range(1, 5), 1'b1);
               repeat ($urandom_range(0, 2)) tick();
            end
            push_done = 1'b1;
         end
         begin
            int guard;
            guard = 0;
            while ((!push_done || sb.size() != 0) && guard < 3000) begin
               @(posedge clk);
               #2;
               guard++;
               out_ack = 1'b0;
               if (out_ready && $urandom_range(0, 1) == 1) begin
                  if (sb.size() == 0) begin
                     chk("rnd_extra", 32'd1, 32'd0);
                  end else begin
                     chk("rnd_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
                     pops_seen++;
                  end
                  out_ack = 1'b1;
               end
            end
            chk("rnd_timeout", {31'd0, (guard >= 3000)}, 32'd0);
            @(posedge clk);
            #2;
            out_ack = 1'b0;
         end
      join
      tick();
      chk("rnd_count",   pops_seen,              32'd40);
      chk("rnd_level",   {27'd0, level},         32'd0);
      chk("rnd_overrun", {31'd0, overrun},       32'd0);

      // reset while the FSM is in SETTLE
      in_ready = 1'b1;
      in_data  = 8'h77;
      tick();
      chk("mid_ack", {31'd0, in_ack}, 32'd1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_level", {27'd0, level},     32'd0);
      chk("mid_rst_rdy",   {31'd0, out_ready}, 32'd0);
      chk("mid_rst_ack",   {31'd0, in_ack},    32'd0);
      in_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      in_ready = 1'b1;
      in_data  = 8'h88;
      tick();
      chk("post_idle_ack", {31'd0, in_ack},   32'd1);
      chk("post_level",    {27'd0, level},    32'd1);
      chk("post_data",     {24'd0, out_data}, 32'h88);
      in_ready = 1'b0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
